// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@60, 40 MHz pixel clock) and helpers.
package vga_pkg;

  localparam int unsigned CNT_W     = 11;
  localparam int unsigned MAX_TOTAL = 2048;

  localparam int unsigned H_TOTAL      = 1056;
  localparam int unsigned H_PIXELS     = 800;
  localparam int unsigned H_SYNC_START = 840;
  localparam int unsigned H_SYNC_END   = 968;

  localparam int unsigned V_TOTAL      = 628;
  localparam int unsigned V_PIXELS     = 600;
  localparam int unsigned V_SYNC_START = 601;
  localparam int unsigned V_SYNC_END   = 605;

  localparam int unsigned SYNC_POL_DEF = 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= val < hi; done in 32 bits so hi may equal MAX_TOTAL.
  function automatic logic in_window(input cnt_t val, input int unsigned lo,
                                     input int unsigned hi);
    return (32'(val) >= lo) && (32'(val) < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and start-of-line/frame strobes aligned to the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HOR_TOTAL      = H_TOTAL,
  parameter int unsigned HOR_PIXELS     = H_PIXELS,
  parameter int unsigned HOR_SYNC_START = H_SYNC_START,
  parameter int unsigned HOR_SYNC_END   = H_SYNC_END,
  parameter int unsigned VER_TOTAL      = V_TOTAL,
  parameter int unsigned VER_PIXELS     = V_PIXELS,
  parameter int unsigned VER_SYNC_START = V_SYNC_START,
  parameter int unsigned VER_SYNC_END   = V_SYNC_END,
  parameter int unsigned SYNC_POL       = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             line_start,
  output logic             frame_start
);

  // Reject illegal timing at elaboration.
  if (!((HOR_PIXELS < HOR_SYNC_START) && (HOR_SYNC_START < HOR_SYNC_END) &&
        (HOR_SYNC_END <= HOR_TOTAL) && (HOR_TOTAL <= MAX_TOTAL))) begin : g_bad_hor
    $error("vga_timing: illegal horizontal timing parameters");
  end
  if (!((VER_PIXELS < VER_SYNC_START) && (VER_SYNC_START < VER_SYNC_END) &&
        (VER_SYNC_END <= VER_TOTAL) && (VER_TOTAL <= MAX_TOTAL))) begin : g_bad_ver
    $error("vga_timing: illegal vertical timing parameters");
  end

  localparam cnt_t H_LAST = CNT_W'(HOR_TOTAL - 1);
  localparam cnt_t V_LAST = CNT_W'(VER_TOTAL - 1);
  localparam logic POL    = (SYNC_POL != 0);

  cnt_t h_nxt;
  cnt_t v_nxt;
  logic h_wrap;
  logic v_wrap;

  // Next raster position if this cycle advances.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = h_wrap ? '0 : hcount + CNT_W'(1);
    v_nxt  = vcount;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vcount + CNT_W'(1);
    end
  end

  // Counters plus decodes of the next position, all registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        hcount      <= h_nxt;
        vcount      <= v_nxt;
        hsync       <= in_window(h_nxt, HOR_SYNC_START, HOR_SYNC_END) ? POL : ~POL;
        vsync       <= in_window(v_nxt, VER_SYNC_START, VER_SYNC_END) ? POL : ~POL;
        hblnk       <= (32'(h_nxt) >= HOR_PIXELS);
        vblnk       <= (32'(v_nxt) >= VER_PIXELS);
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: one default-timing instance and one small,
// active-low instance, both checked every cycle against a raster model.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] d_hc, d_vc, s_hc, s_vc;
  logic d_hs, d_vs, d_hb, d_vb, d_ls, d_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_ls, s_fs;

  vga_timing dut_d (
    .clk(clk), .rst(rst), .en(en),
    .hcount(d_hc), .vcount(d_vc), .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing #(
    .HOR_TOTAL(20), .HOR_PIXELS(12), .HOR_SYNC_START(14), .HOR_SYNC_END(17),
    .VER_TOTAL(10), .VER_PIXELS(6),  .VER_SYNC_START(7),  .VER_SYNC_END(9),
    .SYNC_POL(0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .line_start(s_ls), .frame_start(s_fs)
  );

  // Timing of each instance: index 0 = defaults, index 1 = small.
  int   ht [2] = '{1056, 20};
  int   hp [2] = '{800, 12};
  int   hss[2] = '{840, 14};
  int   hse[2] = '{968, 17};
  int   vt [2] = '{628, 10};
  int   vp [2] = '{600, 6};
  int   vss[2] = '{601, 7};
  int   vse[2] = '{605, 9};
  logic pol[2] = '{1'b1, 1'b0};

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic ls;
    logic fs;
  } exp_t;

  typedef struct {
    exp_t d;
    exp_t s;
  } exp_pair_t;

  exp_pair_t scb[$];

  int   mh [2] = '{0, 0};
  int   mv [2] = '{0, 0};
  logic mls[2] = '{1'b0, 1'b0};
  logic mfs[2] = '{1'b0, 1'b0};

  int errors = 0;
  int checks = 0;

  function automatic exp_t expect_of(input int i);
    exp_t e;
    e.h  = mh[i];
    e.v  = mv[i];
    e.hs = (mh[i] >= hss[i] && mh[i] < hse[i]) ? pol[i] : ~pol[i];
    e.vs = (mv[i] >= vss[i] && mv[i] < vse[i]) ? pol[i] : ~pol[i];
    e.hb = (mh[i] >= hp[i]);
    e.vb = (mv[i] >= vp[i]);
    e.ls = mls[i];
    e.fs = mfs[i];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and queue the raster state it must produce.
  task automatic drive(input logic r, input logic e);
    exp_pair_t p;
    @(negedge clk);
    rst = r;
    en  = e;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mh[i] = 0; mv[i] = 0; mls[i] = 1'b0; mfs[i] = 1'b0;
      end else if (e) begin
        mh[i] = (mh[i] + 1) % ht[i];
        if (mh[i] == 0) mv[i] = (mv[i] + 1) % vt[i];
        mls[i] = (mh[i] == 0);
        mfs[i] = (mh[i] == 0) && (mv[i] == 0);
      end else begin
        mls[i] = 1'b0; mfs[i] = 1'b0;
      end
    end
    p.d = expect_of(0);
    p.s = expect_of(1);
    scb.push_back(p);
  endtask

  // Monitor: compare both instances after every active edge.
  initial begin
    exp_pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() > 0) begin
        p = scb.pop_front();
        check("d_hcount", 32'(d_hc), p.d.h);
        check("d_vcount", 32'(d_vc), p.d.v);
        check("d_hsync",  32'(d_hs), 32'(p.d.hs));
        check("d_vsync",  32'(d_vs), 32'(p.d.vs));
        check("d_hblnk",  32'(d_hb), 32'(p.d.hb));
        check("d_vblnk",  32'(d_vb), 32'(p.d.vb));
        check("d_line_start",  32'(d_ls), 32'(p.d.ls));
        check("d_frame_start", 32'(d_fs), 32'(p.d.fs));
        check("s_hcount", 32'(s_hc), p.s.h);
        check("s_vcount", 32'(s_vc), p.s.v);
        check("s_hsync",  32'(s_hs), 32'(p.s.hs));
        check("s_vsync",  32'(s_vs), 32'(p.s.vs));
        check("s_hblnk",  32'(s_hb), 32'(p.s.hb));
        check("s_vblnk",  32'(s_vb), 32'(p.s.vb));
        check("s_line_start",  32'(s_ls), 32'(p.s.ls));
        check("s_frame_start", 32'(s_fs), 32'(p.s.fs));
        check("s_counters_in_range",
              32'((int'(s_hc) < ht[1]) && (int'(s_vc) < vt[1])), 32'd1);
      end
    end
  end

  // Stimulus.
  initial begin
    logic reached;

    // Reset for three cycles, with en high to show reset wins.
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);

    // Two full default lines plus a little: wraps, sync width, blanking.
    for (int k = 0; k < 2 * 1056 + 10; k++) drive(1'b0, 1'b1);

    // Walk the small instance to its last position, stall, then wrap.
    reached = 1'b0;
    for (int k = 0; k < 1000 && !reached; k++) begin
      drive(1'b0, 1'($urandom_range(0, 3) != 0));
      reached = (mh[1] == 19) && (mv[1] == 9);
    end
    check("reach_last_position", 32'(reached), 32'd1);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);

    // Reset mid-frame on the small instance, then resume counting.
    reached = 1'b0;
    for (int k = 0; k < 1000 && !reached; k++) begin
      drive(1'b0, 1'b1);
      reached = (mh[1] == 10) && (mv[1] == 5);
    end
    check("reach_mid_frame", 32'(reached), 32'd1);
    drive(1'b1, 1'b1);
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1);

    // Random enable over several small frames.
    for (int k = 0; k < 1500; k++) drive(1'b0, 1'($urandom_range(0, 9) < 7));

    // Occasional random reset mixed with random enable.
    for (int k = 0; k < 300; k++)
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
